// File: rtl/muldiv_ctrl_pkg.sv
// Shared CPU package: multDiv controller state encoding and timing.
// Used by the core and by muldiv_ctrl.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_ISSUE = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  localparam int   MD_TIMEOUT  = 40;
  localparam int   MD_CNT_W    = 6;
  localparam logic MD_MODE_MUL = 1'b0;
  localparam logic MD_MODE_DIV = 1'b1;

endpackage

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and issue/wait sequencer for the external multDiv unit.
// Stalls the core while a multu/divu is in flight.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = MD_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_mul,
  input  logic        start_div,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic        md_valid,
  output logic        md_mode,
  output logic [31:0] md_in_A,
  output logic [31:0] md_in_B,
  input  logic        md_ready,
  input  logic [63:0] md_out
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST =
    MD_CNT_W'(TIMEOUT - 1);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q;
  logic                start_any;
  logic                issue;
  logic                div0;
  logic                res_we;
  logic                tmo;

  assign start_any = start_mul | start_div;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    issue   = 1'b0;
    div0    = 1'b0;
    res_we  = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_any) begin
          stall = 1'b1;
          // divide by zero resolves locally, unit never sees it
          if (!start_mul && rt_data == 32'd0) begin
            div0    = 1'b1;
            state_d = MD_DONE;
          end else begin
            issue   = 1'b1;
            state_d = MD_ISSUE;
          end
        end
      end
      MD_ISSUE: begin
        stall   = 1'b1;
        state_d = MD_WAIT;
      end
      MD_WAIT: begin
        stall = 1'b1;
        if (md_ready) begin
          res_we  = 1'b1;
          state_d = MD_DONE;
        end else if (cnt_q == CNT_LAST) begin
          tmo     = 1'b1;
          state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      md_valid <= 1'b0;
      md_mode  <= MD_MODE_MUL;
      md_in_A  <= '0;
      md_in_B  <= '0;
      hi       <= '0;
      lo       <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_valid <= issue;
      cnt_q    <= (state_q == MD_WAIT) ? cnt_q + 1'b1 : '0;
      if (issue) begin
        md_mode <= start_mul ? MD_MODE_MUL : MD_MODE_DIV;
        md_in_A <= rs_data;
        md_in_B <= rt_data;
      end
      if (res_we) begin
        hi <= md_out[63:32];
        lo <= md_out[31:0];
      end else if (div0) begin
        hi <= rs_data;
        lo <= '1;
      end else if (state_q == MD_IDLE && !start_any) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (tmo) err <= 1'b1;
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, maximum WAIT cycles before abort.
REQ-002 SHALL have port clk  in  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_mul / start_div  in  1 each  decoded multu / divu request from core.
REQ-005 SHALL have port rs_data, rt_data  in  32 each  operands: dividend/multiplicand, divisor/multiplier.
REQ-006 SHALL have port hi_we, lo_we, wdata  in  1, 1, 32  mthi/mtlo write.
REQ-007 SHALL have port stall  out  1  freeze core pipeline.
REQ-008 SHALL have port hi, lo  out  32 each  architectural HI/LO registers.
REQ-009 SHALL have port err  out  1  sticky timeout flag.
REQ-010 SHALL have port md_valid, md_mode  out  1, 1  request to multDiv unit (mode 0 multu, 1 divu).
REQ-011 SHALL have port md_in_A, md_in_B  out  32 each  operands to multDiv unit.
REQ-012 SHALL have port md_ready, md_out  in  1, 64  unit completion pulse and result.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT, DONE.
REQ-014 IDLE: start_mul or start_div -> ISSUE; latch md_mode, md_in_A=rs_data, md_in_B=rt_data; start_mul wins if both set.
REQ-015 IDLE: start_div with rt_data==0 -> DONE directly, no issue; hi<=rs_data, lo<=32'hFFFFFFFF.
REQ-016 ISSUE: md_valid=1 for exactly this one cycle (registered), then WAIT unconditionally.
REQ-017 md_valid SHALL be 0 in every state except ISSUE.
REQ-018 md_in_A, md_in_B, md_mode SHALL hold stable from ISSUE until return to IDLE.
REQ-019 WAIT: md_ready=1 -> hi<=md_out[63:32], lo<=md_out[31:0], go DONE.
REQ-020 WAIT: 6-bit wait counter counts WAIT cycles; reaching TIMEOUT without md_ready -> set err, hi/lo unchanged, go DONE.
REQ-021 DONE: stall=0 for one cycle, start_* ignored, then IDLE.
REQ-022 stall SHALL be combinational: 1 in IDLE when start_mul|start_div, 1 in ISSUE and WAIT, else 0.
REQ-023 Nominal multu/divu latency: stall high 35 cycles (request cycle, ISSUE, 33 WAIT incl. ready cycle); results visible on hi/lo in DONE cycle.
REQ-024 hi_we/lo_we SHALL update hi/lo only in IDLE with no start; ignored otherwise; start has priority over write in same cycle.
REQ-025 md_ready outside WAIT SHALL be ignored.
REQ-026 err SHALL stay set until reset.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, md_valid 0, md_mode 0, md_in_A/B 0, hi 0, lo 0, err 0, counter 0; stall then follows REQ-022.
REQ-028 Reset mid-operation SHALL abandon the operation; hi/lo return 0; the multDiv unit shares rst_n.

Structure
REQ-029 State encodings and TIMEOUT default SHALL live in a shared CPU package used by core and controller.
REQ-030 No sub-module; multDiv is instantiated beside, not inside, muldiv_ctrl.

Verification
REQ-031 start_mul, rs=3, rt=5 with real multDiv -> stall 35 cycles, then hi=0, lo=15.
REQ-032 start_div, rs=17, rt=5 -> lo=3, hi=2; md_valid high exactly one cycle.
REQ-033 start_div, rs=7, rt=0 -> md_valid never asserted, hi=7, lo=FFFFFFFF, stall 1 cycle.
REQ-034 lo_we, wdata=AA during WAIT -> lo unchanged; same in IDLE -> lo=AA next cycle.
REQ-035 md_ready tied 0 -> err=1 after 40 WAIT cycles, FSM returns IDLE, hi/lo unchanged.
REQ-036 rst_n low at WAIT cycle 10 -> immediate IDLE, stall 0, hi/lo 0; next start_mul 2*2 -> lo=4.
